// File: rtl/led_pattern_master_if.sv
// ---------------------------------------------------------------------------
// led_pattern_master_if
//
// Avalon-MM bus between the LED pattern initiator and an 8-bit PIO output
// slave. The slave has zero wait states, so there is no waitrequest.
//
// Signals:
//   address    - slave register address (initiator -> slave)
//   chipselect - access qualifier (initiator -> slave)
//   write_n    - active-low write strobe (initiator -> slave)
//   writedata  - write data (initiator -> slave)
//   readdata   - read data, valid in the same cycle (slave -> initiator)
//
// Modports:
//   master - the initiator side (led_pattern_master)
//   slave  - the PIO register side
// ---------------------------------------------------------------------------
interface led_pattern_master_if #(
  parameter int DATA_WIDTH = 8
);
  logic [1:0]            address;
  logic                  chipselect;
  logic                  write_n;
  logic [DATA_WIDTH-1:0] writedata;
  logic [DATA_WIDTH-1:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/led_pattern_master.sv
// ---------------------------------------------------------------------------
// led_pattern_master
//
// Avalon-MM initiator for bring-up of a PIO/LED output register. It
// periodically writes a generated pattern to the slave, reads it straight
// back, and compares. Readback errors set a sticky flag and bump a
// saturating 8-bit counter.
//
// Transaction: IDLE -> WRITE -> READ -> CHECK -> WAIT(PERIOD cycles) ->
// WRITE ..., so write strobes are PERIOD+3 cycles apart while enabled.
//
// Parameters:
//   DATA_WIDTH   - width of writedata/readdata/pattern (>= 2)
//   TARGET_ADDR  - slave register address used for every access
//   PERIOD       - idle cycles between transactions (>= 1)
//   INIT_PATTERN - pattern value after reset
//
// Ports:
//   clk       - system clock
//   reset     - synchronous, active-high reset
//   enable    - run request; sampled in IDLE and at the end of WAIT
//   mode      - pattern generator: 0 walk-one, 1 count, 2 invert, 3 hold
//   clear     - clears mismatch and err_count
//   bus       - Avalon-MM master port (address/chipselect/write_n/
//               writedata out, readdata in)
//   pattern   - current pattern value
//   mismatch  - sticky readback-error flag
//   err_count - saturating readback-error count
//   busy      - high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module led_pattern_master #(
  parameter int                    DATA_WIDTH   = 8,
  parameter logic [1:0]            TARGET_ADDR  = 2'd0,
  parameter int                    PERIOD       = 16,
  parameter logic [DATA_WIDTH-1:0] INIT_PATTERN = 8'h01
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [1:0]             mode,
  input  logic                   clear,
  led_pattern_master_if.master   bus,
  output logic [DATA_WIDTH-1:0]  pattern,
  output logic                   mismatch,
  output logic [7:0]             err_count,
  output logic                   busy
);

  // Wide enough to hold PERIOD-1; at least one bit when PERIOD is 1.
  localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PERIOD - 1);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    CHECK,
    WAIT
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] pattern_q, pattern_d;
  logic [DATA_WIDTH-1:0] rd_q, rd_d;
  logic                  mismatch_q, mismatch_d;
  logic [7:0]            err_q, err_d;
  logic [1:0]            addr_q, addr_d;
  logic                  cs_q, cs_d;
  logic                  wn_q, wn_d;
  logic [DATA_WIDTH-1:0] wd_q, wd_d;
  logic                  busy_q, busy_d;

  // Pattern generator step.
  function automatic logic [DATA_WIDTH-1:0] next_pattern(
    input logic [DATA_WIDTH-1:0] p,
    input logic [1:0]            m
  );
    logic [DATA_WIDTH-1:0] n;
    n = p;
    case (m)
      2'd0: begin
        // An all-zero value would rotate forever as zero; restart the walk.
        if (p == '0) n = DATA_WIDTH'(1);
        else         n = {p[DATA_WIDTH-2:0], p[DATA_WIDTH-1]};
      end
      2'd1:    n = p + DATA_WIDTH'(1);
      2'd2:    n = ~p;
      default: n = p;
    endcase
    return n;
  endfunction

  // Increment that sticks at 255.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pattern_q  <= INIT_PATTERN;
      rd_q       <= '0;
      mismatch_q <= 1'b0;
      err_q      <= 8'd0;
      addr_q     <= 2'd0;
      cs_q       <= 1'b0;
      wn_q       <= 1'b1;
      wd_q       <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pattern_q  <= pattern_d;
      rd_q       <= rd_d;
      mismatch_q <= mismatch_d;
      err_q      <= err_d;
      addr_q     <= addr_d;
      cs_q       <= cs_d;
      wn_q       <= wn_d;
      wd_q       <= wd_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pattern_d  = pattern_q;
    rd_d       = rd_q;
    mismatch_d = mismatch_q;
    err_d      = err_q;
    wd_d       = wd_q;
    addr_d     = addr_q;

    if (clear) begin
      mismatch_d = 1'b0;
      err_d      = 8'd0;
    end

    case (state_q)
      IDLE: begin
        if (enable) state_d = WRITE;
      end
      WRITE: begin
        state_d = READ;
      end
      READ: begin
        // Zero-wait slave: readdata is valid in this cycle.
        rd_d    = bus.readdata;
        state_d = CHECK;
      end
      CHECK: begin
        if (rd_q != pattern_q) begin
          mismatch_d = 1'b1;
          // A coincident clear wipes the history but keeps this error.
          err_d      = clear ? 8'd1 : sat_inc(err_q);
        end
        pattern_d = next_pattern(pattern_q, mode);
        cnt_d     = CNT_LOAD;
        state_d   = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) state_d = enable ? WRITE : IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase

    // Bus outputs are registered, so they are decoded from the next state.
    // writedata is loaded only on entry to WRITE and held otherwise.
    cs_d   = (state_d == WRITE) || (state_d == READ);
    wn_d   = (state_d != WRITE);
    busy_d = (state_d != IDLE);
    if (state_d == WRITE) wd_d   = pattern_q;
    if (cs_d)             addr_d = TARGET_ADDR;
  end

  assign bus.address    = addr_q;
  assign bus.chipselect = cs_q;
  assign bus.write_n    = wn_q;
  assign bus.writedata  = wd_q;
  assign pattern        = pattern_q;
  assign mismatch       = mismatch_q;
  assign err_count      = err_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_led_pattern_master.sv
// Bench for led_pattern_master: PIO slave model with a readback mask,
// scoreboard of expected writes (value, error state at the strobe).
module tb_led_pattern_master;

  localparam int         PERIOD = 2;
  localparam logic [1:0] ADDR   = 2'd1;
  localparam logic [7:0] INIT   = 8'h01;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       clear = 1'b0;
  logic [7:0] pattern;
  logic       mismatch;
  logic [7:0] err_count;
  logic       busy;

  led_pattern_master_if #(.DATA_WIDTH(8)) bus();

  led_pattern_master #(
    .DATA_WIDTH  (8),
    .TARGET_ADDR (ADDR),
    .PERIOD      (PERIOD),
    .INIT_PATTERN(INIT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .mode     (mode),
    .clear    (clear),
    .bus      (bus),
    .pattern  (pattern),
    .mismatch (mismatch),
    .err_count(err_count),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // PIO slave: one register, readback passes through a fault mask.
  logic [7:0] led_q;
  logic [7:0] rd_mask = 8'hFF;
  always @(posedge clk) begin
    if (reset) led_q <= 8'h00;
    else if (bus.chipselect && !bus.write_n && bus.address == ADDR)
      led_q <= bus.writedata;
  end
  assign bus.readdata = led_q & rd_mask;

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [7:0] wd;
    logic [7:0] err;
    logic       mis;
  } exp_t;
  exp_t sb_q[$];

  // Reference state
  logic [7:0] p_m   = INIT;
  logic [7:0] err_m = 8'd0;
  logic       mis_m = 1'b0;

  function automatic logic [7:0] model_next(input logic [7:0] p,
                                            input logic [1:0] m);
    case (m)
      2'd0:    return (p == 8'h00) ? 8'h01 : {p[6:0], p[7]};
      2'd1:    return p + 8'd1;
      2'd2:    return ~p;
      default: return p;
    endcase
  endfunction

  // Monitor
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int strobe_cnt = 0;
  int batch_id   = 0;
  int last_batch = -1;
  int last_cyc   = 0;
  always @(negedge clk) begin
    if (bus.chipselect && !bus.write_n) begin
      strobe_cnt++;
      if (sb_q.size() == 0) begin
        check_val("unexpected_wr", 32'(bus.writedata), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_val("wdata", 32'(bus.writedata), 32'(e.wd));
        check_val("addr", 32'(bus.address), 32'(ADDR));
        check_val("err_at_wr", 32'(err_count), 32'(e.err));
        check_val("mis_at_wr", 32'(mismatch), 32'(e.mis));
      end
      if (last_batch == batch_id)
        check_val("spacing", 32'(cyc - last_cyc), 32'(PERIOD + 3));
      last_batch = batch_id;
      last_cyc   = cyc;
    end
  end

  // Run n transactions in mode m, then drop enable during WAIT.
  // clr_last pulses clear in the CHECK cycle of the last transaction.
  task automatic run_batch(input logic [1:0] m, input int n,
                           input bit clr_last);
    int target;
    int guard;
    bit fail;
    for (int k = 0; k < n; k++) begin
      exp_t e;
      e.wd = p_m; e.err = err_m; e.mis = mis_m;
      sb_q.push_back(e);
      fail = ((p_m & rd_mask) != p_m);
      if (clr_last && k == n - 1) begin
        err_m = fail ? 8'd1 : 8'd0;
        mis_m = fail;
      end else if (fail) begin
        err_m = (err_m == 8'hFF) ? err_m : err_m + 8'd1;
        mis_m = 1'b1;
      end
      p_m = model_next(p_m, m);
    end
    batch_id++;
    target = strobe_cnt + n;
    mode   = m;
    enable = 1'b1;
    guard  = 0;
    while (strobe_cnt < target && guard < n * (PERIOD + 3) + 20) begin
      @(posedge clk);
      guard++;
    end
    if (strobe_cnt < target) check_val("batch_timeout", 32'(strobe_cnt), 32'(target));
    @(posedge clk);
    #1 clear = clr_last;
    @(posedge clk);
    #1 clear = 1'b0;
    enable = 1'b0;
    guard = 0;
    while (busy && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check_val("busy_idle", 32'(busy), 32'd0);
    check_val("cs_idle", 32'(bus.chipselect), 32'd0);
    check_val("sb_left", 32'(sb_q.size()), 32'd0);
    check_val("pattern_end", 32'(pattern), 32'(p_m));
    check_val("err_end", 32'(err_count), 32'(err_m));
    check_val("mis_end", 32'(mismatch), 32'(mis_m));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_cs", 32'(bus.chipselect), 32'd0);
    check_val("rst_wn", 32'(bus.write_n), 32'd1);
    check_val("rst_addr", 32'(bus.address), 32'd0);
    check_val("rst_wd", 32'(bus.writedata), 32'd0);
    check_val("rst_pat", 32'(pattern), 32'(INIT));
    check_val("rst_err", 32'(err_count), 32'd0);
    check_val("rst_mis", 32'(mismatch), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Walking one twice round, then invert 0x01 -> 0xFE
    run_batch(2'd0, 16, 1'b0);
    run_batch(2'd2, 1, 1'b0);
    // Count across the wrap, then walking one out of zero
    run_batch(2'd1, 2, 1'b0);
    run_batch(2'd0, 2, 1'b0);
    // Count up to 0x55
    run_batch(2'd1, 83, 1'b0);
    // bit0 stuck low: 0x55 fails, 0xAA passes
    rd_mask = 8'hFE;
    run_batch(2'd2, 6, 1'b0);
    // Idle clear
    @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    err_m = 8'd0; mis_m = 1'b0;
    @(negedge clk);
    check_val("clr_err", 32'(err_count), 32'd0);
    check_val("clr_mis", 32'(mismatch), 32'd0);
    run_batch(2'd2, 4, 1'b0);
    // Clear coincident with a failing CHECK
    run_batch(2'd2, 1, 1'b1);
    // Readback stuck at zero, hold: saturation
    rd_mask = 8'h00;
    run_batch(2'd3, 300, 1'b0);
    check_val("sat_err", 32'(err_count), 32'hFF);

    // Reset in the middle of WRITE
    begin
      exp_t e;
      bit found;
      e.wd = p_m; e.err = err_m; e.mis = mis_m;
      sb_q.push_back(e);
      batch_id++;
      enable = 1'b1;
      found = 1'b0;
      for (int g = 0; g < 20 && !found; g++) begin
        @(negedge clk);
        if (bus.chipselect && !bus.write_n) found = 1'b1;
      end
      check_val("rst_wr_seen", 32'(found), 32'd1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check_val("mrst_cs", 32'(bus.chipselect), 32'd0);
      check_val("mrst_wn", 32'(bus.write_n), 32'd1);
      check_val("mrst_pat", 32'(pattern), 32'(INIT));
      check_val("mrst_err", 32'(err_count), 32'd0);
      check_val("mrst_mis", 32'(mismatch), 32'd0);
      check_val("mrst_busy", 32'(busy), 32'd0);
      enable = 1'b0;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check_val("post_rst_busy", 32'(busy), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_pattern_master.md
Name: led_pattern_master

Overview:
Avalon-MM initiator that drives an 8-bit PIO output slave, such as the LED register at address 0 in the same SOPC system. It periodically writes a generated pattern to the slave, then reads it back and checks it. Mismatches are reported through a sticky flag and a saturating error counter. Used for board bring-up and for self-checking the PIO/LED path without a CPU.

Parameters:
DATA_WIDTH, 8, width of writedata/readdata/pattern
TARGET_ADDR, 0, 2-bit slave register address used for every access
PERIOD, 16, idle cycles between transactions (minimum 1)
INIT_PATTERN, 8'h01, pattern value after reset

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  run when high; sampled in IDLE and at the end of WAIT
mode  in  2  pattern generator: 0 walking-one, 1 binary count, 2 invert, 3 hold
clear  in  1  clears mismatch and err_count
address  out  2  Avalon address to slave
chipselect  out  1  Avalon chipselect
write_n  out  1  Avalon write strobe, active low
writedata  out  DATA_WIDTH  Avalon write data
readdata  in  DATA_WIDTH  Avalon read data from slave, zero wait states
pattern  out  DATA_WIDTH  current pattern value
mismatch  out  1  sticky readback-error flag
err_count  out  8  saturating count of readback errors
busy  out  1  high whenever state != IDLE

Behaviour:
- One clock domain. Reset is synchronous and active-high. Clock port is clk; reset port is reset.
- Reset values:
  - state=IDLE, chipselect=0, write_n=1, address=0, writedata=0.
  - pattern=INIT_PATTERN, mismatch=0, err_count=0, busy=0.
  - Wait counter=0, captured read value=0.
- All outputs are registered.
- FSM states: IDLE, WRITE, READ, CHECK, WAIT.
- IDLE:
  - Bus idle: chipselect=0, write_n=1.
  - enable=1 -> WRITE on the next edge.
- WRITE (1 cycle):
  - chipselect=1, write_n=0, address=TARGET_ADDR, writedata=pattern.
  - -> READ.
- READ (1 cycle):
  - chipselect=1, write_n=1, address=TARGET_ADDR.
  - readdata is captured at the closing edge.
  - -> CHECK.
- CHECK (1 cycle):
  - Bus idle.
  - If the captured value != pattern: mismatch<=1, and err_count<=err_count+1, saturating at 255.
  - pattern<=next(pattern, mode); wait counter<=PERIOD-1.
  - -> WAIT.
- WAIT:
  - Bus idle; counter decrements each cycle.
  - At counter==0: enable=1 -> WRITE, else -> IDLE.
  - enable is ignored before counter==0, so a transaction always completes.
- Transaction spacing: write strobes are exactly PERIOD+3 cycles apart while enabled.
- next(pattern, mode):
  - 0 (walking-one): rotate left by 1; if pattern==0, next=1.
  - 1 (binary count): pattern+1, wrapping from all-ones to 0.
  - 2 (invert): bitwise invert, e.g. 0x55<->0xAA.
  - 3 (hold): unchanged.
  - mode is sampled only in CHECK; a mode change mid-transaction affects the next pattern only.
- pattern is retained across enable pauses. Only reset reloads INIT_PATTERN.
- clear:
  - clear=1 zeroes mismatch and err_count in any state.
  - If clear and a CHECK error occur in the same cycle, the result is mismatch=1, err_count=1.
- Reset mid-operation, in any state: the next edge yields the full reset values and the bus idles immediately. No partial write is completed.
- writedata holds its last value outside WRITE. chipselect=0 in those states makes it don't-care to the slave.

Test Plan:
1. PIO slave model attached, INIT=0x01, PERIOD=2, mode=0, enable=1 -> writes 0x01,0x02,0x04,…,0x80,0x01; write_n low every 5 cycles; mismatch=0, err_count=0.
2. INIT=0xFE, mode=1 -> successive writes 0xFE, 0xFF, 0x00, 0x01; no errors.
3. Slave model with readdata bit0 stuck at 0, INIT=0x55, mode=2 -> 0x55 fails (mismatch=1, err_count=1); 0xAA passes; err_count increments every second transaction; clear pulse -> both return to 0, then resume counting.
4. readdata tied to 0x00, mode=3, INIT=0x01, 300 transactions -> err_count saturates at 255 and stays there; mismatch=1.
5. enable dropped during WAIT -> finishes WAIT, enters IDLE, busy=0, chipselect=0; re-enable -> the next write carries the advanced pattern, not INIT.
6. reset asserted during WRITE -> next cycle chipselect=0, write_n=1, pattern=INIT_PATTERN, err_count=0, state IDLE.
